// File: rtl/calc_key_decoder.sv
// calc_key_decoder: turns keypad key codes into a two-operand hex calculator.
// Digits shift into operand A or B. Operator keys latch the operation. EXE
// evaluates A op B. In the result state an operator chains from the result,
// and a digit starts a new calculation.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   key_val    5-bit key code (0x00-0x0F digit, 0x10-0x17 commands)
//   key_valid  key_val is valid this cycle
//   key_ready  key can be accepted (low while computing)
//   display    A in S_OPA, B in S_OPB, result in S_CALC/S_RES
//   op_code    latched operation (0 ADD, 1 MUL, 2 AND, 3 SUB, 4 OR)
//   state      0 S_OPA, 1 S_OPB, 2 S_CALC, 3 S_RES
//   ovf        overflow flag, present only when CALC_OVF_EN is defined
//
// Build option: define CALC_OVF_EN to add the ovf port and overflow tracking.
module calc_key_decoder #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       key_val,
  input  logic             key_valid,
  output logic             key_ready,
  output logic [WIDTH-1:0] display,
  output logic [2:0]       op_code,
`ifdef CALC_OVF_EN
  output logic             ovf,
`endif
  output logic [1:0]       state
);

  localparam int unsigned NDIG = WIDTH / 4;
  localparam int unsigned CW   = $clog2(NDIG + 1);
  localparam int unsigned MW   = $clog2(WIDTH);
`ifdef CALC_OVF_EN
  // Full-width product and carry/borrow bit are kept for overflow detection.
  localparam int unsigned PW   = 2 * WIDTH;
  localparam int unsigned SW   = WIDTH + 1;
`else
  localparam int unsigned PW   = WIDTH;
  localparam int unsigned SW   = WIDTH;
`endif

  typedef enum logic [1:0] {
    S_OPA  = 2'd0,
    S_OPB  = 2'd1,
    S_CALC = 2'd2,
    S_RES  = 2'd3
  } state_t;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_MUL = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;

  localparam logic [4:0] K_ADD = 5'h10;
  localparam logic [4:0] K_MUL = 5'h11;
  localparam logic [4:0] K_AND = 5'h12;
  localparam logic [4:0] K_EXE = 5'h13;
  localparam logic [4:0] K_SUB = 5'h14;
  localparam logic [4:0] K_OR  = 5'h15;
  localparam logic [4:0] K_CE  = 5'h16;
  localparam logic [4:0] K_CLR = 5'h17;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_a, w_a_nxt;
  logic [WIDTH-1:0] r_b, w_b_nxt;
  logic [PW-1:0]    r_acc, w_acc_nxt;
  logic [PW-1:0]    r_mcand, w_mcand_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic [MW-1:0]    r_mcnt, w_mcnt_nxt;
  logic [2:0]       r_op, w_op_nxt;
  logic             r_ready, w_ready_nxt;
  logic [WIDTH-1:0] r_disp, w_disp_nxt;
`ifdef CALC_OVF_EN
  logic             r_ovf, w_ovf_nxt;
`endif

  logic             w_accept;
  logic             w_is_digit, w_is_oper, w_is_exe, w_is_ce, w_is_clr;
  logic [2:0]       w_key_op;
  logic [SW-1:0]    w_sum, w_dif;

  assign w_accept = key_valid && r_ready;
  assign w_sum    = SW'(r_a) + SW'(r_b);
  assign w_dif    = SW'(r_a) - SW'(r_b);

  // Key classification; codes 0x18-0x1F fall through as no-ops.
  always_comb begin
    w_is_digit = ~key_val[4];
    w_is_oper  = 1'b0;
    w_is_exe   = 1'b0;
    w_is_ce    = 1'b0;
    w_is_clr   = 1'b0;
    w_key_op   = OP_ADD;
    case (key_val)
      K_ADD: begin w_is_oper = 1'b1; w_key_op = OP_ADD; end
      K_MUL: begin w_is_oper = 1'b1; w_key_op = OP_MUL; end
      K_AND: begin w_is_oper = 1'b1; w_key_op = OP_AND; end
      K_SUB: begin w_is_oper = 1'b1; w_key_op = OP_SUB; end
      K_OR:  begin w_is_oper = 1'b1; w_key_op = OP_OR;  end
      K_EXE: w_is_exe = 1'b1;
      K_CE:  w_is_ce  = 1'b1;
      K_CLR: w_is_clr = 1'b1;
      default: ;
    endcase
  end

  // Next-state and datapath
  always_comb begin
    w_state_nxt = r_state;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_acc_nxt   = r_acc;
    w_mcand_nxt = r_mcand;
    w_cnt_nxt   = r_cnt;
    w_mcnt_nxt  = r_mcnt;
    w_op_nxt    = r_op;
`ifdef CALC_OVF_EN
    w_ovf_nxt   = r_ovf;
`endif

    if (w_accept && w_is_clr) begin
      w_state_nxt = S_OPA;
      w_a_nxt     = '0;
      w_b_nxt     = '0;
      w_acc_nxt   = '0;
      w_mcand_nxt = '0;
      w_cnt_nxt   = '0;
      w_mcnt_nxt  = '0;
      w_op_nxt    = OP_ADD;
`ifdef CALC_OVF_EN
      w_ovf_nxt   = 1'b0;
`endif
    end else begin
      case (r_state)
        S_OPA: begin
          if (w_accept) begin
            if (w_is_digit) begin
              if (r_cnt < CW'(NDIG)) begin
                w_a_nxt   = {r_a[WIDTH-5:0], key_val[3:0]};
                w_cnt_nxt = r_cnt + CW'(1);
              end
            end else if (w_is_oper) begin
              w_op_nxt    = w_key_op;
              w_b_nxt     = '0;
              w_cnt_nxt   = '0;
              w_state_nxt = S_OPB;
            end else if (w_is_ce) begin
              w_a_nxt   = '0;
              w_cnt_nxt = '0;
            end
          end
        end
        S_OPB: begin
          if (w_accept) begin
            if (w_is_digit) begin
              if (r_cnt < CW'(NDIG)) begin
                w_b_nxt   = {r_b[WIDTH-5:0], key_val[3:0]};
                w_cnt_nxt = r_cnt + CW'(1);
              end
            end else if (w_is_oper) begin
              // The operator can only be changed before any B digit.
              if (r_cnt == '0) w_op_nxt = w_key_op;
            end else if (w_is_ce) begin
              w_b_nxt   = '0;
              w_cnt_nxt = '0;
            end else if (w_is_exe) begin
              w_acc_nxt   = '0;
              w_mcand_nxt = PW'(r_a);
              w_mcnt_nxt  = '0;
              w_state_nxt = S_CALC;
`ifdef CALC_OVF_EN
              w_ovf_nxt   = 1'b0;
`endif
            end
          end
        end
        S_CALC: begin
          if (r_op == OP_MUL) begin
            // Shift-add: B is consumed LSB first, one bit per cycle.
            if (r_b[0]) w_acc_nxt = r_acc + r_mcand;
            w_mcand_nxt = r_mcand << 1;
            w_b_nxt     = r_b >> 1;
            w_mcnt_nxt  = r_mcnt + MW'(1);
            if (r_mcnt == MW'(WIDTH - 1)) begin
              w_state_nxt = S_RES;
`ifdef CALC_OVF_EN
              w_ovf_nxt   = |w_acc_nxt[PW-1:WIDTH];
`endif
            end
          end else begin
            case (r_op)
              OP_ADD: begin
                w_acc_nxt = PW'(w_sum[WIDTH-1:0]);
`ifdef CALC_OVF_EN
                w_ovf_nxt = w_sum[WIDTH];
`endif
              end
              OP_SUB: begin
                w_acc_nxt = PW'(w_dif[WIDTH-1:0]);
`ifdef CALC_OVF_EN
                w_ovf_nxt = w_dif[WIDTH];
`endif
              end
              OP_AND:  w_acc_nxt = PW'(r_a & r_b);
              default: w_acc_nxt = PW'(r_a | r_b);
            endcase
            w_state_nxt = S_RES;
          end
        end
        default: begin
          if (w_accept) begin
            if (w_is_digit) begin
              w_a_nxt     = WIDTH'(key_val[3:0]);
              w_cnt_nxt   = CW'(1);
              w_state_nxt = S_OPA;
            end else if (w_is_oper) begin
              // Chain: the result becomes the next A operand.
              w_a_nxt     = r_acc[WIDTH-1:0];
              w_op_nxt    = w_key_op;
              w_b_nxt     = '0;
              w_cnt_nxt   = '0;
              w_state_nxt = S_OPB;
            end
          end
        end
      endcase
    end

    w_ready_nxt = (w_state_nxt != S_CALC);
    case (w_state_nxt)
      S_OPA:   w_disp_nxt = w_a_nxt;
      S_OPB:   w_disp_nxt = w_b_nxt;
      default: w_disp_nxt = w_acc_nxt[WIDTH-1:0];
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_OPA;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_mcand <= '0;
      r_cnt   <= '0;
      r_mcnt  <= '0;
      r_op    <= OP_ADD;
      r_ready <= 1'b1;
      r_disp  <= '0;
`ifdef CALC_OVF_EN
      r_ovf   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
      r_acc   <= w_acc_nxt;
      r_mcand <= w_mcand_nxt;
      r_cnt   <= w_cnt_nxt;
      r_mcnt  <= w_mcnt_nxt;
      r_op    <= w_op_nxt;
      r_ready <= w_ready_nxt;
      r_disp  <= w_disp_nxt;
`ifdef CALC_OVF_EN
      r_ovf   <= w_ovf_nxt;
`endif
    end
  end

  assign key_ready = r_ready;
  assign display   = r_disp;
  assign op_code   = r_op;
  assign state     = r_state;
`ifdef CALC_OVF_EN
  assign ovf       = r_ovf;
`endif

endmodule

// File: tb/tb_calc_key_decoder.sv
// tb_calc_key_decoder: directed key sequences for calc_key_decoder. Each
// stimulus step queues the output snapshot it should produce; a monitor pops
// and compares whenever the DUT presents a new output (key accepted, reset,
// or calculation finished).
module tb_calc_key_decoder;

  typedef struct {
    logic [15:0] disp;
    logic [2:0]  op;
    logic [1:0]  st;
    logic        rdy;
    logic        ovf;
    logic        cd;
  } exp_t;

  localparam logic [4:0] K_ADD = 5'h10;
  localparam logic [4:0] K_MUL = 5'h11;
  localparam logic [4:0] K_AND = 5'h12;
  localparam logic [4:0] K_EXE = 5'h13;
  localparam logic [4:0] K_SUB = 5'h14;
  localparam logic [4:0] K_OR  = 5'h15;
  localparam logic [4:0] K_CE  = 5'h16;
  localparam logic [4:0] K_CLR = 5'h17;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  key_val;
  logic        key_valid;
  logic        key_ready;
  logic [15:0] display;
  logic [2:0]  op_code;
  logic [1:0]  state;
`ifdef CALC_OVF_EN
  logic        ovf;
`endif

  int checks = 0;
  int passed = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  calc_key_decoder #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_val   (key_val),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .display   (display),
    .op_code   (op_code),
`ifdef CALC_OVF_EN
    .ovf       (ovf),
`endif
    .state     (state)
  );

  function automatic exp_t mk(input logic [15:0] d, input logic [2:0] o,
                              input logic [1:0] s, input logic r,
                              input logic v, input logic c);
    exp_t e;
    e.disp = d; e.op = o; e.st = s; e.rdy = r; e.ovf = v; e.cd = c;
    return e;
  endfunction

  function automatic exp_t sa(input logic [15:0] d, input logic [2:0] o, input logic v);
    return mk(d, o, 2'd0, 1'b1, v, 1'b1);
  endfunction
  function automatic exp_t sb(input logic [15:0] d, input logic [2:0] o, input logic v);
    return mk(d, o, 2'd1, 1'b1, v, 1'b1);
  endfunction
  function automatic exp_t sr(input logic [15:0] d, input logic [2:0] o, input logic v);
    return mk(d, o, 2'd3, 1'b1, v, 1'b1);
  endfunction
  function automatic exp_t ex(input logic [2:0] o);
    return mk(16'h0, o, 2'd2, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic exp_t rs();
    return mk(16'h0, 3'd0, 2'd0, 1'b1, 1'b0, 1'b1);
  endfunction

  // Monitor: an output event is a key accepted or reset asserted at the
  // previous negedge, or the S_CALC -> S_RES transition.
  logic       prev_acc = 1'b0;
  logic       prev_rst = 1'b0;
  logic [1:0] prev_st  = 2'd0;
  always @(negedge clk) begin
    exp_t e;
    logic ev;
    logic ok;
    ev = prev_acc || prev_rst || (prev_st === 2'd2 && state === 2'd3);
    if (ev) begin
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_event state=%0d display=%h", state, display);
      end else begin
        e = exp_q.pop_front();
        ok = (state === e.st) && (op_code === e.op) && (key_ready === e.rdy) &&
             (!e.cd || display === e.disp);
`ifdef CALC_OVF_EN
        ok = ok && (ovf === e.ovf);
`endif
        if (ok) passed++;
        else
          $display("FAIL output_check #%0d: got disp=%h op=%0d st=%0d rdy=%b, required disp=%h(chk=%b) op=%0d st=%0d rdy=%b ovf=%b",
                   checks, display, op_code, state, key_ready,
                   e.disp, e.cd, e.op, e.st, e.rdy, e.ovf);
      end
    end
    prev_acc = (key_valid === 1'b1) && (key_ready === 1'b1);
    prev_rst = (rst === 1'b1);
    prev_st  = state;
  end

  // Offer a key until accepted; called and returns just after a posedge.
  task automatic press(input logic [4:0] k, input exp_t e);
    int n;
    exp_q.push_back(e);
    key_val   = k;
    key_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (key_ready !== 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (key_ready !== 1'b1) begin
      checks++;
      $display("FAIL key_accept_timeout key=%h ready=%b required 1", k, key_ready);
    end
    @(posedge clk);
    #1;
    key_valid = 1'b0;
  endtask

  // EXE, then count the cycles key_ready stays low; optionally hold a key.
  task automatic run_exe(input exp_t e_exe, input exp_t e_res, input int cyc,
                         input logic held, input logic [4:0] hk, input exp_t e_held);
    int n;
    press(K_EXE, e_exe);
    exp_q.push_back(e_res);
    if (held) begin
      exp_q.push_back(e_held);
      key_val   = hk;
      key_valid = 1'b1;
    end
    n = 0;
    @(negedge clk);
    while (key_ready !== 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n == cyc) passed++;
    else $display("FAIL calc_cycles got=%0d required=%0d", n, cyc);
    @(posedge clk);
    #1;
    key_valid = 1'b0;
  endtask

  task automatic do_reset();
    exp_q.push_back(rs());
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    key_val   = 5'h0;
    key_valid = 1'b0;
    exp_q.push_back(rs());
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // 12 ADD 3
    press(5'h1, sa(16'h0001, 3'd0, 1'b0));
    press(5'h2, sa(16'h0012, 3'd0, 1'b0));
    press(K_ADD, sb(16'h0000, 3'd0, 1'b0));
    press(5'h3, sb(16'h0003, 3'd0, 1'b0));
    run_exe(ex(3'd0), sr(16'h0015, 3'd0, 1'b0), 1, 1'b0, 5'h0, rs());

    // Digit limit and CE
    press(5'h1, sa(16'h0001, 3'd0, 1'b0));
    press(5'h2, sa(16'h0012, 3'd0, 1'b0));
    press(5'h3, sa(16'h0123, 3'd0, 1'b0));
    press(5'h4, sa(16'h1234, 3'd0, 1'b0));
    press(5'h5, sa(16'h1234, 3'd0, 1'b0));
    press(K_CE, sa(16'h0000, 3'd0, 1'b0));

    // 0x00FF MUL 0x0101 with a key held during the multiply
    press(5'hF, sa(16'h000F, 3'd0, 1'b0));
    press(5'hF, sa(16'h00FF, 3'd0, 1'b0));
    press(K_MUL, sb(16'h0000, 3'd1, 1'b0));
    press(5'h0, sb(16'h0000, 3'd1, 1'b0));
    press(5'h1, sb(16'h0001, 3'd1, 1'b0));
    press(5'h0, sb(16'h0010, 3'd1, 1'b0));
    press(5'h1, sb(16'h0101, 3'd1, 1'b0));
    run_exe(ex(3'd1), sr(16'hFFFF, 3'd1, 1'b0), 16, 1'b1, 5'h7, sa(16'h0007, 3'd1, 1'b0));

    // 3 SUB 5, then chained ADD 2
    press(K_CE, sa(16'h0000, 3'd1, 1'b0));
    press(5'h3, sa(16'h0003, 3'd1, 1'b0));
    press(K_SUB, sb(16'h0000, 3'd3, 1'b0));
    press(5'h5, sb(16'h0005, 3'd3, 1'b0));
    run_exe(ex(3'd3), sr(16'hFFFE, 3'd3, 1'b1), 1, 1'b0, 5'h0, rs());
    press(K_ADD, sb(16'h0000, 3'd0, 1'b1));
    press(5'h2, sb(16'h0002, 3'd0, 1'b1));
    run_exe(ex(3'd0), sr(16'h0000, 3'd0, 1'b1), 1, 1'b0, 5'h0, rs());

    // CLR in S_RES, operator replacement, ignored keys
    press(K_CLR, rs());
    press(K_EXE, sa(16'h0000, 3'd0, 1'b0));
    press(5'h9, sa(16'h0009, 3'd0, 1'b0));
    press(K_ADD, sb(16'h0000, 3'd0, 1'b0));
    press(K_MUL, sb(16'h0000, 3'd1, 1'b0));
    press(5'h7, sb(16'h0007, 3'd1, 1'b0));
    press(K_AND, sb(16'h0007, 3'd1, 1'b0));
    press(5'h18, sb(16'h0007, 3'd1, 1'b0));
    run_exe(ex(3'd1), sr(16'h003F, 3'd1, 1'b0), 16, 1'b0, 5'h0, rs());
    press(5'h1F, sr(16'h003F, 3'd1, 1'b0));
    press(K_EXE, sr(16'h003F, 3'd1, 1'b0));
    press(K_CE, sr(16'h003F, 3'd1, 1'b0));

    // Reset five cycles into a multiply
    press(K_MUL, sb(16'h0000, 3'd1, 1'b0));
    press(5'h3, sb(16'h0003, 3'd1, 1'b0));
    press(K_EXE, ex(3'd1));
    repeat (4) @(posedge clk);
    #1;
    do_reset();

    // CLR in S_OPB
    press(5'h4, sa(16'h0004, 3'd0, 1'b0));
    press(K_OR, sb(16'h0000, 3'd4, 1'b0));
    press(5'h6, sb(16'h0006, 3'd4, 1'b0));
    press(K_CLR, rs());

    // OR and chained AND
    press(5'hC, sa(16'h000C, 3'd0, 1'b0));
    press(K_OR, sb(16'h0000, 3'd4, 1'b0));
    press(5'h3, sb(16'h0003, 3'd4, 1'b0));
    run_exe(ex(3'd4), sr(16'h000F, 3'd4, 1'b0), 1, 1'b0, 5'h0, rs());
    press(K_AND, sb(16'h0000, 3'd2, 1'b0));
    press(5'h5, sb(16'h0005, 3'd2, 1'b0));
    run_exe(ex(3'd2), sr(16'h0005, 3'd2, 1'b0), 1, 1'b0, 5'h0, rs());

    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() == 0) passed++;
    else $display("FAIL pending_expectations got=%0d required=0", exp_q.size());

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
